// File: rtl/fpu_multiplier_pipe.sv
// Three-stage pipelined floating-point multiplier with a valid/ready stream interface.
// S1 unpacks, classifies and multiplies. S2 normalises and extracts guard/sticky bits.
// S3 rounds (RNE or RTZ), saturates and packs the result.
// One global advance signal moves every stage forward together, so the pipe freezes
// as a unit under backpressure.
module fpu_multiplier_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] float1,
  input  logic [EXP_W+MAN_W:0] float2,
  input  logic                 rnd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;

  localparam logic [EXP_W-1:0]        EXP_ALL1 = '1;
  localparam logic [EXP_W-1:0]        EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic signed [EW-1:0]    BIAS     = EW'((1 << (EXP_W-1)) - 1);
  localparam logic signed [EW-1:0]    OVF_LIM  = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]            QNAN     = {1'b0, EXP_ALL1, 1'b1, {(MAN_W-1){1'b0}}};

  // Round-to-nearest-even increment decision; round-toward-zero never increments.
  function automatic logic round_inc(input logic rtz, input logic guard,
                                     input logic sticky, input logic lsb);
    return !rtz && guard && (sticky || lsb);
  endfunction

  // Saturating pack of a finite rounded value: overflow, flush-to-zero underflow or normal.
  function automatic logic [W+3:0] pack_normal(input logic sign,
                                               input logic signed [EW-1:0] esum,
                                               input logic [MAN_W-1:0] man,
                                               input logic inexact,
                                               input logic rtz);
    if (esum >= OVF_LIM) begin
      if (rtz)
        return {sign, EXP_MAXF, {MAN_W{1'b1}}, 4'b0110};
      else
        return {sign, EXP_ALL1, {MAN_W{1'b0}}, 4'b0110};
    end else if (esum[EW-1] || esum == '0) begin
      return {sign, {(EXP_W+MAN_W){1'b0}}, 4'b0011};
    end else begin
      return {sign, esum[EXP_W-1:0], man, 3'b000, inexact};
    end
  endfunction

  logic adv;
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

  // ---- S1: unpack / classify / multiply ----
  logic                 sign_a, sign_b;
  logic [EXP_W-1:0]     exp_a, exp_b;
  logic [MAN_W-1:0]     frac_a, frac_b;
  logic                 zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic                 sign_s1, spc_s1;
  logic [W-1:0]         spc_res_s1;
  logic [3:0]           spc_flags_s1;
  logic signed [EW-1:0] esum_s1;
  logic [PW-1:0]        prod_s1;

  assign {sign_a, exp_a, frac_a} = float1;
  assign {sign_b, exp_b, frac_b} = float2;

  // Denormal inputs have exp == 0 and are treated as zero of the same sign.
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (exp_a == EXP_ALL1) && (frac_a == '0);
  assign inf_b  = (exp_b == EXP_ALL1) && (frac_b == '0);
  assign nan_a  = (exp_a == EXP_ALL1) && (frac_a != '0);
  assign nan_b  = (exp_b == EXP_ALL1) && (frac_b != '0);

  assign sign_s1 = sign_a ^ sign_b;
  assign esum_s1 = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;
  assign prod_s1 = PW'({1'b1, frac_a}) * PW'({1'b1, frac_b});

  // Special-operand result, decided here and carried past rounding.
  always_comb begin
    spc_s1       = 1'b1;
    spc_res_s1   = '0;
    spc_flags_s1 = 4'b0000;
    if (nan_a || nan_b) begin
      spc_res_s1 = QNAN;
    end else if ((zero_a && inf_b) || (inf_a && zero_b)) begin
      spc_res_s1   = QNAN;
      spc_flags_s1 = 4'b1000;
    end else if (inf_a || inf_b) begin
      spc_res_s1 = {sign_s1, EXP_ALL1, {MAN_W{1'b0}}};
    end else if (zero_a || zero_b) begin
      spc_res_s1 = {sign_s1, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      spc_s1 = 1'b0;
    end
  end

  logic                 vld_p0, sign_p0, rnd_p0, spc_p0;
  logic signed [EW-1:0] esum_p0;
  logic [PW-1:0]        prod_p0;
  logic [W-1:0]         spc_res_p0;
  logic [3:0]           spc_flags_p0;

  // S1 data register, loaded only when an operand pair enters.
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      sign_p0      <= sign_s1;
      rnd_p0       <= rnd_mode;
      spc_p0       <= spc_s1;
      esum_p0      <= esum_s1;
      prod_p0      <= prod_s1;
      spc_res_p0   <= spc_res_s1;
      spc_flags_p0 <= spc_flags_s1;
    end
  end

  // ---- S2: normalise, extract fraction / guard / sticky ----
  logic [PW-2:0]        norm_s2;
  logic signed [EW-1:0] esum_s2;

  // Product lies in [1,4); a set MSB means the value is in [2,4) and needs one right shift.
  assign norm_s2 = prod_p0[PW-1] ? prod_p0[PW-2:0] : {prod_p0[PW-3:0], 1'b0};
  assign esum_s2 = esum_p0 + $signed({{(EW-1){1'b0}}, prod_p0[PW-1]});

  logic                 vld_p1, sign_p1, rnd_p1, spc_p1, guard_p1, sticky_p1;
  logic signed [EW-1:0] esum_p1;
  logic [MAN_W-1:0]     man_p1;
  logic [W-1:0]         spc_res_p1;
  logic [3:0]           spc_flags_p1;

  // S2 data register, loaded only when S1 holds a live operation.
  always_ff @(posedge clk) begin
    if (adv && vld_p0) begin
      sign_p1      <= sign_p0;
      rnd_p1       <= rnd_p0;
      spc_p1       <= spc_p0;
      esum_p1      <= esum_s2;
      man_p1       <= norm_s2[2*MAN_W:MAN_W+1];
      guard_p1     <= norm_s2[MAN_W];
      sticky_p1    <= |norm_s2[MAN_W-1:0];
      spc_res_p1   <= spc_res_p0;
      spc_flags_p1 <= spc_flags_p0;
    end
  end

  // ---- S3: round / saturate / pack ----
  logic                 carry_s3;
  logic [MAN_W-1:0]     man_s3;
  logic signed [EW-1:0] esum_s3;
  logic [W+3:0]         packed_s3;

  // Rounding; a carry out of the fraction leaves it zero and bumps the exponent.
  always_comb begin
    {carry_s3, man_s3} = {1'b0, man_p1}
                         + SW'(round_inc(rnd_p1, guard_p1, sticky_p1, man_p1[0]));
    esum_s3 = esum_p1 + $signed({{(EW-1){1'b0}}, carry_s3});
    if (spc_p1)
      packed_s3 = {spc_res_p1, spc_flags_p1};
    else
      packed_s3 = pack_normal(sign_p1, esum_s3, man_s3, guard_p1 | sticky_p1, rnd_p1);
  end

  logic vld_p2;
  assign out_valid = vld_p2;

  // Stage valid bits: cleared by reset, shifted together on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Output register: zeroed by reset, holds steady while stalled or during bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      flags  <= 4'b0000;
    end else if (adv && vld_p1) begin
      result <= packed_s3[W+3:4];
      flags  <= packed_s3[3:0];
    end
  end

endmodule

// File: tb/tb_fpu_multiplier_pipe.sv
// Scoreboard bench for fpu_multiplier_pipe at default binary32 widths.
// Expected results come from an arithmetic reference model (exact integer product,
// remainder-versus-half rounding); a monitor pops and compares every delivered result.
module tb_fpu_multiplier_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] float1, float2;
  logic        rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  fpu_multiplier_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .float1(float1), .float2(float2), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          received = 0;
  int          stall_left = 0;
  bit          rand_ready = 1'b0;
  bit          held_valid = 1'b0;
  logic [31:0] held_res;
  logic [3:0]  held_fl;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact significand product, rounding by comparing the discarded remainder to half an ulp.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic rm,
                                output logic [31:0] r, output logic [3:0] f);
    int ea, eb, e, sh;
    logic s;
    longint unsigned p, q, rem, half;
    bit za, zb, ia, ib;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    f  = 4'b0000;
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) begin
      r = 32'h7FC00000;
      return;
    end
    if ((za && ib) || (ia && zb)) begin
      r = 32'h7FC00000;
      f = 4'b1000;
      return;
    end
    if (ia || ib) begin
      r = {s, 8'hFF, 23'd0};
      return;
    end
    if (za || zb) begin
      r = {s, 31'd0};
      return;
    end
    p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e++;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (!rm && (rem > half || (rem == half && q[0]))) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) begin
      r = rm ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'd0};
      f = 4'b0110;
    end else if (e <= 0) begin
      r = {s, 31'd0};
      f = 4'b0011;
    end else begin
      r = {s, e[7:0], q[22:0]};
      f = {3'b000, rem != 0};
    end
  endfunction

  // Consumer side: scripted stalls or random readiness.
  always @(negedge clk) begin
    if (rand_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: stall stability, then pop-and-compare on every output transfer.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (rst) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_result", 64'(result), 64'(held_res));
        check("stall_flags", 64'(flags), 64'(held_fl));
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 64'(in_ready), 64'd0);
        held_valid = 1'b1;
        held_res   = result;
        held_fl    = flags;
      end else begin
        held_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        received++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h flags %h expected no output (cycle %0d)",
                   result, flags, cyc);
        end else begin
          e = sb_q.pop_front();
          check("result", 64'(result), 64'(e.res));
          check("flags", 64'(flags), 64'(e.fl));
          if (e.lat) check("latency", 64'(cyc - e.acc), 64'd3);
        end
      end
    end
  end

  // Present one operation and hold it until accepted; push its expectation on acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic rm, input bit lat);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    float1   = a;
    float2   = b;
    rnd_mode = rm;
    in_valid = 1'b1;
    forever begin
      #2;
      if (in_ready && !rst) begin
        model(a, b, rm, e.res, e.fl);
        e.acc = cyc;
        e.lat = lat;
        sb_q.push_back(e);
        break;
      end
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready 0 expected acceptance within 200 cycles");
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    idle(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 9))
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       e = 8'd1;
      3:       e = 8'd254;
      4, 5, 6: e = 8'($urandom_range(100, 154));
      default: e = 8'($urandom_range(0, 255));
    endcase
    case ($urandom_range(0, 5))
      0:       m = 23'd0;
      1:       m = 23'h7FFFFF;
      default: m = 23'($urandom);
    endcase
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  logic [31:0] dir_a  [0:16] = '{32'h3F800000, 32'h40000000, 32'hBFC00000, 32'h41200000,
                                 32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h3FFFFFFF,
                                 32'h3FFFFFFF, 32'h7F000000, 32'h7F000000, 32'h00800000,
                                 32'h00000000, 32'h80000000, 32'h7FC12345, 32'hFF800000,
                                 32'h00000001};
  logic [31:0] dir_b  [0:16] = '{32'h3F800000, 32'h3F000000, 32'h40000000, 32'hC1200000,
                                 32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h3FFFFFFF,
                                 32'h3FFFFFFF, 32'h7F000000, 32'h7F000000, 32'h00800000,
                                 32'h7F800000, 32'h42F6E979, 32'h3F800000, 32'h40000000,
                                 32'h40000000};
  logic        dir_rm [0:16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int r0;
    rst      = 1'b1;
    in_valid = 1'b0;
    float1   = '0;
    float2   = '0;
    rnd_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'(flags), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, each in an empty pipe so latency is exact.
    for (int i = 0; i < 17; i++) begin
      send(dir_a[i], dir_b[i], dir_rm[i], 1'b1);
      drain();
    end

    // Back-to-back stream with a three-cycle consumer stall in the middle.
    r0 = received;
    for (int i = 0; i < 6; i++) begin
      send(32'h3F800000 + 32'(i) * 32'h00100000, 32'h40400000, 1'(i % 2), 1'b0);
      if (i == 3) stall_left = 3;
    end
    drain();
    check("stream_count", 64'(received - r0), 64'd6);

    // Reset with three operations in flight; an operand offered during reset must be dropped.
    for (int i = 0; i < 3; i++) send(32'h40A00000 + 32'(i), 32'h3FC00000, 1'b0, 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    float1   = 32'h41000000;
    float2   = 32'h41000000;
    sb_q.delete();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_result", 64'(result), 64'd0);
    check("midreset_flags", 64'(flags), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    r0 = received;
    idle(8);
    check("midreset_no_stale", 64'(received - r0), 64'd0);
    send(32'h40400000, 32'hC0800000, 1'b0, 1'b1);
    drain();

    // Randomised operands, rounding modes and consumer readiness.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    rand_ready = 1'b0;
    drain();

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
